// File: rtl/key_pkg.sv
// Shared types and helpers for the debounced key front end.
package key_pkg;

    // Per-key event FSM: waiting for a press, timing the long press, or auto-repeating.
    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } key_state_t;

    // Internal level that means "pressed", whatever the pin polarity.
    localparam logic KEY_PRESSED = 1'b1;

    // Polarity helper: maps a raw pin to the internal pressed level.
    function automatic logic pin_to_pressed(input logic active_low, input logic pin);
        return (active_low ? ~pin : pin) == KEY_PRESSED;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One key channel: two-flop synchroniser, debounce filter and the
// press / long / repeat / release event FSM with registered pulse outputs.
module key_channel
    import key_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned HOLD_CYCLES     = 25_000_000,
    parameter int unsigned REPEAT_CYCLES   = 5_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,           // 1 = pressed, already polarity-corrected
    output logic pressed,
    output logic held,
    output logic released,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_TERM = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] REP_TERM  = HW'(REPEAT_CYCLES);
    localparam logic [HW-1:0] HCNT_ONE  = HW'(1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [DW-1:0] dcnt;

    logic          accept;
    logic          rise;
    logic          fall;

    key_state_t    state;
    logic [HW-1:0] hcnt;

    // Synchronise the pin and accept a new level only after it has disagreed
    // with the debounced state for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            dcnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                dcnt <= '0;
            end else if (dcnt == DEB_LAST) begin
                stable <= sync2;
                dcnt   <= '0;
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    // Edge of the debounced level that takes effect at the coming clock edge,
    // so the FSM outputs line up with the update of stable.
    always_comb begin
        accept = (sync2 != stable) && (dcnt == DEB_LAST);
        rise   = accept && sync2;
        fall   = accept && !sync2;
    end

    // Event FSM; release has priority over a long or repeat due on the same edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            hcnt         <= '0;
            pressed      <= 1'b0;
            released     <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            pressed      <= 1'b0;
            released     <= 1'b0;
            long_press   <= 1'b0;
            repeat_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state        <= HOLD;
                        hcnt         <= HCNT_ONE;
                        pressed      <= 1'b1;
                        repeat_pulse <= 1'b1;
                    end
                end
                HOLD: begin
                    if (fall) begin
                        state    <= IDLE;
                        hcnt     <= '0;
                        released <= 1'b1;
                    end else if (hcnt == HOLD_TERM) begin
                        state        <= REPEAT;
                        hcnt         <= HCNT_ONE;
                        long_press   <= 1'b1;
                        repeat_pulse <= 1'b1;
                    end else begin
                        hcnt <= hcnt + HCNT_ONE;
                    end
                end
                REPEAT: begin
                    if (fall) begin
                        state    <= IDLE;
                        hcnt     <= '0;
                        released <= 1'b1;
                    end else if (hcnt == REP_TERM) begin
                        hcnt         <= HCNT_ONE;
                        repeat_pulse <= 1'b1;
                    end else begin
                        hcnt <= hcnt + HCNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    hcnt  <= '0;
                end
            endcase
        end
    end

    // The debounced level is itself a register, so it drives key_held directly.
    assign held = stable;

endmodule

// File: rtl/key_event_unit.sv
// Debounced multi-key front end: applies pin polarity and instantiates one
// independent key_channel per key.
module key_event_unit
    import key_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned HOLD_CYCLES     = 25_000_000,
    parameter int unsigned REPEAT_CYCLES   = 5_000_000
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_released,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    logic [NUM_KEYS-1:0] raw;

    // Normalise every pin so that 1 means pressed inside the channels.
    always_comb begin
        raw = '0;
        for (int i = 0; i < int'(NUM_KEYS); i++) begin
            raw[i] = pin_to_pressed(ACTIVE_LOW, KEY[i]);
        end
    end

    for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_key
        key_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_channel (
            .clk          (clk),
            .resetn       (resetn),
            .raw          (raw[i]),
            .pressed      (key_pressed[i]),
            .held         (key_held[i]),
            .released     (key_released[i]),
            .long_press   (key_long[i]),
            .repeat_pulse (key_repeat[i])
        );
    end

endmodule

// File: tb/tb_key_event_unit.sv
// Directed bench for key_event_unit with DEBOUNCE=4, HOLD=10, REPEAT=3.
// Two instances share clock and reset: one active-low, one active-high.
module tb_key_event_unit;

    logic       clk;
    logic       resetn;
    logic [3:0] key_lo;
    logic [3:0] key_hi;

    logic [3:0] lo_pressed, lo_held, lo_released, lo_long, lo_repeat;
    logic [3:0] hi_pressed, hi_held, hi_released, hi_long, hi_repeat;

    int errors = 0;
    int checks = 0;

    key_event_unit #(
        .NUM_KEYS        (4),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .KEY          (key_lo),
        .key_pressed  (lo_pressed),
        .key_held     (lo_held),
        .key_released (lo_released),
        .key_long     (lo_long),
        .key_repeat   (lo_repeat)
    );

    key_event_unit #(
        .NUM_KEYS        (4),
        .ACTIVE_LOW      (1'b0),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (3)
    ) dut_hi (
        .clk          (clk),
        .resetn       (resetn),
        .KEY          (key_hi),
        .key_pressed  (hi_pressed),
        .key_held     (hi_held),
        .key_released (hi_released),
        .key_long     (hi_long),
        .key_repeat   (hi_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {pressed, held, released, long, repeat} of a key held from
    // first sample edge 1; t is the edge count since that sample.
    function automatic logic [4:0] clean_exp(input int t);
        logic p, h, l, r;
        p = (t == 6);
        h = (t >= 6);
        l = (t == 16);
        r = (t == 6) || (t == 16) || (t > 16 && ((t - 16) % 3) == 0);
        return {p, h, 1'b0, l, r};
    endfunction

    task automatic do_reset();
        key_lo = 4'hF;
        key_hi = 4'h0;
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [19:0] all_lo;
        resetn = 1'b0;
        key_lo = 4'h0;
        key_hi = 4'h0;
        tick(); tick(); tick();
        all_lo = {lo_pressed, lo_held, lo_released, lo_long, lo_repeat};
        checks++;
        if (all_lo !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=%h", all_lo, 20'h0);
        end
        resetn = 1'b1;
        for (int t = 1; t <= 6; t++) begin
            tick();
            checks++;
            if (lo_pressed !== ((t == 6) ? 4'hF : 4'h0)) begin
                errors++;
                $display("FAIL reset_first_press t=%0d got=%b exp=%b", t, lo_pressed,
                         (t == 6) ? 4'hF : 4'h0);
            end
        end
        checks++;
        if ({lo_held, lo_repeat} !== 8'hFF) begin
            errors++;
            $display("FAIL reset_press_held_repeat got=%h exp=ff", {lo_held, lo_repeat});
        end
        // Reset while the pins remain pressed: outputs clear, no release event.
        resetn = 1'b0;
        tick();
        all_lo = {lo_pressed, lo_held, lo_released, lo_long, lo_repeat};
        checks++;
        if (all_lo !== 20'h0) begin
            errors++;
            $display("FAIL midpress_reset got=%h exp=%h", all_lo, 20'h0);
        end
        tick();
        resetn = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            checks++;
            if ({lo_pressed, lo_released} !== {((t == 6) ? 4'hF : 4'h0), 4'h0}) begin
                errors++;
                $display("FAIL midpress_repress t=%0d got=%b/%b exp=%b/0000", t, lo_pressed,
                         lo_released, (t == 6) ? 4'hF : 4'h0);
            end
        end
        do_reset();
    endtask

    task automatic test_clean_press();
        logic [4:0] got;
        logic [4:0] exp;
        key_lo = 4'b1110;
        for (int t = 1; t <= 26; t++) begin
            tick();
            got = {lo_pressed[0], lo_held[0], lo_released[0], lo_long[0], lo_repeat[0]};
            exp = clean_exp(t);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL clean_key0 t=%0d got=%b exp=%b", t, got, exp);
            end
            checks++;
            if ({lo_pressed[3:1], lo_held[3:1], lo_released[3:1], lo_long[3:1],
                 lo_repeat[3:1]} !== 15'h0) begin
                errors++;
                $display("FAIL clean_others t=%0d got=%h exp=0", t,
                         {lo_pressed[3:1], lo_held[3:1], lo_released[3:1], lo_long[3:1],
                          lo_repeat[3:1]});
            end
        end
        do_reset();
    endtask

    task automatic test_bounce();
        logic [19:0] all_lo;
        logic [4:0]  got;
        logic [4:0]  exp;
        key_lo = 4'b1101;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 3) key_lo = 4'hF;
            all_lo = {lo_pressed, lo_held, lo_released, lo_long, lo_repeat};
            checks++;
            if (all_lo !== 20'h0) begin
                errors++;
                $display("FAIL bounce_short t=%0d got=%h exp=0", t, all_lo);
            end
        end
        key_lo = 4'b1101;
        for (int t = 1; t <= 14; t++) begin
            tick();
            if (t == 4) key_lo = 4'hF;
            got = {lo_pressed[1], lo_held[1], lo_released[1], lo_long[1], lo_repeat[1]};
            exp = {t == 6, (t >= 6 && t < 10), t == 10, 1'b0, t == 6};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL bounce_accept t=%0d got=%b exp=%b", t, got, exp);
            end
        end
        do_reset();
    endtask

    task automatic test_release_before_long();
        logic [4:0] got;
        logic [4:0] exp;
        key_lo = 4'b1011;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (t == 5) key_lo = 4'hF;
            got = {lo_pressed[2], lo_held[2], lo_released[2], lo_long[2], lo_repeat[2]};
            exp = {t == 6, (t >= 6 && t < 11), t == 11, 1'b0, t == 6};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL release_early t=%0d got=%b exp=%b", t, got, exp);
            end
        end
        do_reset();
    endtask

    task automatic test_release_vs_repeat();
        logic [4:0] got;
        logic [4:0] exp;
        key_lo = 4'b0111;
        for (int t = 1; t <= 26; t++) begin
            tick();
            if (t == 13) key_lo = 4'hF;
            got = {lo_pressed[3], lo_held[3], lo_released[3], lo_long[3], lo_repeat[3]};
            if (t < 19)       exp = clean_exp(t);
            else if (t == 19) exp = 5'b00100;
            else              exp = 5'b00000;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL release_vs_repeat t=%0d got=%b exp=%b", t, got, exp);
            end
        end
        do_reset();
    endtask

    task automatic test_polarity_independence();
        logic [4:0] got0;
        logic [4:0] got3;
        logic [4:0] exp3;
        key_hi = 4'b0001;
        for (int t = 1; t <= 26; t++) begin
            tick();
            got0 = {hi_pressed[0], hi_held[0], hi_released[0], hi_long[0], hi_repeat[0]};
            got3 = {hi_pressed[3], hi_held[3], hi_released[3], hi_long[3], hi_repeat[3]};
            exp3 = clean_exp(t - 2);
            checks++;
            if (got0 !== clean_exp(t)) begin
                errors++;
                $display("FAIL hi_key0 t=%0d got=%b exp=%b", t, got0, clean_exp(t));
            end
            checks++;
            if (got3 !== exp3) begin
                errors++;
                $display("FAIL hi_key3 t=%0d got=%b exp=%b", t, got3, exp3);
            end
            checks++;
            if ({hi_pressed[2:1], hi_held[2:1], hi_released[2:1], hi_long[2:1],
                 hi_repeat[2:1], lo_pressed, lo_held, lo_released, lo_long,
                 lo_repeat} !== 30'h0) begin
                errors++;
                $display("FAIL hi_silent t=%0d got=%h exp=0", t,
                         {hi_pressed[2:1], hi_held[2:1], hi_released[2:1], hi_long[2:1],
                          hi_repeat[2:1], lo_pressed, lo_held, lo_released, lo_long,
                          lo_repeat});
            end
            if (t == 2) key_hi = 4'b1001;
        end
        do_reset();
    endtask

    initial begin
        resetn = 1'b0;
        key_lo = 4'h0;
        key_hi = 4'h0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_before_long();
        test_release_vs_repeat();
        test_polarity_independence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_event_unit.md
# key_event_unit

Parametrised, debounced key front end. It turns NUM_KEYS raw push-button inputs into clean per-key events for the game controller:
- press and release pulses;
- held level;
- long-press pulse;
- auto-repeat pulse train.

It sits between the board KEY pins and the tile-hit and menu logic. It replaces the plain edge detector by adding metastability synchronisation, debouncing, configurable polarity and hold timing.

## Interface
- NUM_KEYS, 4: number of independent key channels (1..16).
- ACTIVE_LOW, 1: 1 means a pin at 0 is pressed; 0 means a pin at 1 is pressed.
- DEBOUNCE_CYCLES, 1000: consecutive stable cycles required to accept a level change (>=1).
- HOLD_CYCLES, 25_000_000: cycles after the accepted press until key_long fires (>=2).
- REPEAT_CYCLES, 5_000_000: auto-repeat period after key_long (>=1).
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- KEY  in  NUM_KEYS  raw asynchronous key pins.
- key_pressed  out  NUM_KEYS  one-cycle pulse on accepted press.
- key_held  out  NUM_KEYS  level; high while the debounced state is pressed.
- key_released  out  NUM_KEYS  one-cycle pulse on accepted release.
- key_long  out  NUM_KEYS  one-cycle pulse once per press, after HOLD_CYCLES held.
- key_repeat  out  NUM_KEYS  one-cycle pulse at press, at long, then every REPEAT_CYCLES.

## Operation
- Every channel is identical and independent. There is no cross-key interaction.
- Polarity: raw = ACTIVE_LOW ? ~KEY : KEY, so 1 always means pressed internally.

Synchroniser:
- Two flops (sync1, sync2) per key.

Debounce:
- stable is the debounced state; dcnt is the debounce counter.
- If sync2 == stable: dcnt <= 0.
- Else if dcnt == DEBOUNCE_CYCLES-1: stable <= sync2 and dcnt <= 0.
- Else: dcnt <= dcnt+1.
- A disagreement shorter than DEBOUNCE_CYCLES produces no event and restarts the count.

Per-key FSM:
- States are IDLE, HOLD and REPEAT. hcnt is the hold/repeat counter.
- IDLE -> HOLD on the edge where stable goes 0->1. On that edge: key_pressed=1, key_repeat=1, hcnt=1.
- HOLD: hcnt increments each cycle. When hcnt == HOLD_CYCLES: key_long=1, key_repeat=1, hcnt <= 1, go to REPEAT.
- REPEAT: hcnt increments each cycle. When hcnt == REPEAT_CYCLES: key_repeat=1, hcnt <= 1.
- HOLD or REPEAT -> IDLE on the edge where stable goes 1->0. On that edge: key_released=1, hcnt <= 0.
- Release has priority. If release coincides with a pending long or repeat, only key_released fires.
- key_held equals stable, registered.
- Counter widths are $clog2(param+1). Counters never wrap, because each is reloaded at its terminal value.

## Timing
- Reset (resetn=0 at an edge) sets:
  - sync1, sync2 and stable to 0 (released);
  - all counters to 0;
  - FSM to IDLE;
  - every output to 0.
- Reset mid-press: the key is treated as released. If the pin is still pressed afterwards, a fresh press is reported with normal latency, and no key_released is emitted.
- Press latency: KEY settled and first sampled at edge 1 -> key_pressed, key_held and key_repeat high after edge DEBOUNCE_CYCLES+2.
- Release latency is identical and measured to key_released.
- key_long is high after edge P+HOLD_CYCLES, where P is the press edge.
- Subsequent key_repeat pulses occur at P+HOLD_CYCLES+k*REPEAT_CYCLES, k>=1.
- Pulses last exactly one cycle. key_pressed and key_released are never high together on the same key.
- Minimum press-to-release spacing is DEBOUNCE_CYCLES cycles.

## Structure
- Package key_pkg holds:
  - enum key_state_t {IDLE, HOLD, REPEAT};
  - the polarity helper constant.
- Sub-module key_channel holds one channel (sync, debounce, FSM, counters). The top level instantiates it NUM_KEYS times in a generate loop and applies polarity.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3 and ACTIVE_LOW=1.
- Reset: hold resetn=0 with KEY=4'b0000 -> all outputs 0. After release of reset, key_pressed=4'b1111 six cycles after the first sampling edge.
- Clean press on key 0: KEY[0] 1->0 and held -> key_pressed[0] pulse at edge 6, key_long[0] at edge 16, key_repeat[0] at edges 6, 16, 19, 22.
- Bounce rejection: KEY[1] low for 3 cycles, then high -> no event on any output. KEY[1] low for 4 cycles -> key_pressed[1] pulse.
- Release before long: press key 2, release at press+5 -> key_released[2] 6 cycles after the release sample, with no key_long[2].
- Release colliding with repeat: arrange stable 1->0 on the same edge as a scheduled repeat -> key_released only, FSM IDLE, key_repeat 0.
- Independence and polarity: rerun the clean-press scenario with ACTIVE_LOW=0 and keys 0 and 3 pressed 2 cycles apart -> identical waveforms offset by 2 cycles, keys 1 and 2 silent.
